// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared defaults and count type for the modulo down counter
package counter_pkg;

   localparam int DEFAULT_MOD   = 9;
   localparam int DEFAULT_WIDTH = 4;

   typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/t_ff_sync.sv
// rtl/t_ff_sync.sv - T flip-flop with synchronous active-high reset to RESET_VAL
module t_ff_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/mod_9_down_counter.sv
// rtl/mod_9_down_counter.sv - modulo-MOD down counter built from T flip-flops
// Parallel load is compiled in only when DOWN_COUNTER_LOAD_EN is defined.
module mod_9_down_counter
   import counter_pkg::*;
#(
   parameter int MOD   = DEFAULT_MOD,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] borrow;
   logic [WIDTH-1:0] toggle;
   logic             at_zero;

   assign at_zero = (count == '0);
   assign tc      = at_zero & en;

   // Bit i flips on a decrement exactly when every lower bit is 0.
   always_comb begin
      borrow[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         borrow[i] = borrow[i-1] & ~count[i-1];
      end
   end

`ifdef DOWN_COUNTER_LOAD_EN
   logic [WIDTH-1:0] load_target;

   assign load_target = (32'(load_val) >= MOD) ? MAX_VAL : load_val;

   always_comb begin
      toggle = '0;
      if (load) begin
         toggle = count ^ load_target;
      end else if (en && at_zero) begin
         toggle = count ^ MAX_VAL;
      end else if (en) begin
         toggle = borrow;
      end
   end
`else
   always_comb begin
      toggle = '0;
      if (en && at_zero) begin
         toggle = count ^ MAX_VAL;
      end else if (en) begin
         toggle = borrow;
      end
   end
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff_sync #(
         .RESET_VAL(MAX_VAL[i])
      ) u_tff (
         .clk(clk),
         .rst(rst),
         .t  (toggle[i]),
         .q  (count[i])
      );
   end

endmodule

// File: tb/tb_mod_9_down_counter.sv
// tb/tb_mod_9_down_counter.sv - scoreboard bench for mod_9_down_counter
module tb_mod_9_down_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;

   int tests_run;
   int tests_failed;

   logic [3:0] exp_q[$];
   logic [3:0] exp_cnt;
   logic       exp_valid;

   mod_9_down_counter #(.MOD(9), .WIDTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .load_val(load_val),
      .count   (count),
      .tc      (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: drive inputs, check tc on the falling edge, check count after the rising edge.
   task automatic step(input logic r, input logic e, input logic l, input logic [3:0] lv, input string name);
      logic [3:0] nxt;
      logic [3:0] got;
      logic       exp_tc;
      rst = r; en = e; load = l; load_val = lv;
      if (r) begin
         nxt = 4'd8;
      end else begin
`ifdef DOWN_COUNTER_LOAD_EN
         if (l) nxt = (lv >= 4'd9) ? 4'd8 : lv;
         else if (e) nxt = (exp_cnt == 4'd0) ? 4'd8 : exp_cnt - 4'd1;
         else nxt = exp_cnt;
`else
         if (e) nxt = (exp_cnt == 4'd0) ? 4'd8 : exp_cnt - 4'd1;
         else nxt = exp_cnt;
`endif
      end
      exp_q.push_back(nxt);
      @(negedge clk);
      if (exp_valid) begin
         exp_tc = (exp_cnt == 4'd0) && e;
         tests_run++;
         if (tc !== exp_tc) begin
            tests_failed++;
            $display("FAIL %s tc: got %b expected %b (count exp %0d)", name, tc, exp_tc, exp_cnt);
         end
      end
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      exp_cnt = got;
      exp_valid = 1'b1;
      tests_run++;
      if (count !== got) begin
         tests_failed++;
         $display("FAIL %s count: got %0d expected %0d", name, count, got);
      end
   endtask

   task automatic run_to(input logic [3:0] target, input string name);
      for (int i = 0; i < 12 && exp_cnt != target; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'd0, name);
      end
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 4'd0, "reset0");
      step(1'b1, 1'b0, 1'b0, 4'd5, "reset1");
      tests_run++;
      if (count !== 4'd8 || tc !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got count=%0d tc=%b expected count=8 tc=0", count, tc);
      end
   endtask

   task automatic test_count_sequence();
      logic [3:0] seq [10];
      seq = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd8};
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (count !== seq[i]) begin
            tests_failed++;
            $display("FAIL seq_%0d: got %0d expected %0d", i, count, seq[i]);
         end
         step(1'b0, 1'b1, 1'b0, 4'd0, "count_seq");
      end
   endtask

   task automatic test_hold();
      run_to(4'd5, "to_five");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 4'(i), "hold");
      end
      tests_run++;
      if (count !== 4'd5) begin
         tests_failed++;
         $display("FAIL hold_final: got %0d expected 5", count);
      end
   endtask

`ifdef DOWN_COUNTER_LOAD_EN
   task automatic test_load();
      step(1'b0, 1'b1, 1'b1, 4'd3, "load3");
      step(1'b0, 1'b1, 1'b1, 4'd12, "load12_clamp");
      step(1'b0, 1'b0, 1'b1, 4'd9, "load9_clamp");
      step(1'b0, 1'b0, 1'b1, 4'd0, "load0");
      // tc stays high at count 0 even while a load is applied
      step(1'b0, 1'b1, 1'b1, 4'd6, "load_at_zero");
   endtask
`else
   task automatic test_load_ignored();
      run_to(4'd6, "to_six");
      step(1'b0, 1'b1, 1'b1, 4'd2, "load_ignored");
      tests_run++;
      if (count !== 4'd5) begin
         tests_failed++;
         $display("FAIL load_ignored_final: got %0d expected 5", count);
      end
      step(1'b0, 1'b0, 1'b1, 4'd1, "load_ignored_hold");
   endtask
`endif

   task automatic test_reset_wins();
      run_to(4'd0, "to_zero");
      step(1'b1, 1'b1, 1'b1, 4'd2, "reset_wins");
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0, 1'b0, 4'd0, "b2b_reset");
      step(1'b0, 1'b1, 1'b0, 4'd0, "resume");
      tests_run++;
      if (count !== 4'd7) begin
         tests_failed++;
         $display("FAIL resume_first: got %0d expected 7", count);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), "random");
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      exp_valid = 1'b0;
      exp_cnt = 4'd0;
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_count_sequence();
      test_hold();
`ifdef DOWN_COUNTER_LOAD_EN
      test_load();
`else
      test_load_ignored();
`endif
      test_reset_wins();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
